otbn_mac_bignum_iter: RTL
=========================

Name: otbn_mac_bignum_iter

Overview:
Parametrised, multi-cycle successor to the OTBN bignum MAC. It has one MulW x MulW multiplier, NumAcc independent accumulators and two modes. SINGLE mode performs one limb product plus accumulate. ROW mode multiplies every limb of operand A by one limb of operand B over NumLimbs cycles. It sits in the bignum datapath beside the ALU, is driven by the controller with a start/done handshake, and exposes its accumulators as ISPRs.

Parameters:
Width, 256, datapath/accumulator width in bits.
MulW, 64, multiplier operand width; Width % MulW == 0 required (elaboration assertion).
NumAcc, 2, number of accumulator registers (>=1).
Derived localparams: NumLimbs = Width/MulW; SelW = max(1,$clog2(NumLimbs)); AccW = max(1,$clog2(NumAcc)).

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset
start_i  in  1  operation request; accepted only when busy_o=0
mode_row_i  in  1  0=SINGLE, 1=ROW
operand_a_i  in  Width  operand A
operand_b_i  in  Width  operand B
a_sel_i  in  SelW  A limb select (SINGLE only)
b_sel_i  in  SelW  B limb select
shift_i  in  SelW  pre-accumulate shift in limbs (SINGLE only)
zero_acc_i  in  1  start from 0 instead of the accumulator
shift_acc_i  in  1  .SO: write back the upper half, shifted down
wr_hw_upper_i  in  1  .SO half-word select (flag enables only)
acc_sel_i  in  AccW  accumulator index
abort_i  in  1  cancel the in-flight operation
busy_o  out  1  operation in flight
done_o  out  1  one-cycle result-valid pulse
result_o  out  Width  full sum, valid while done_o=1
flags_o  out  4  {Z,L,M,C}, valid while done_o=1
flags_en_o  out  4  per-flag enables, valid while done_o=1
acc_rd_idx_i  in  AccW  ISPR read index
acc_rd_data_o  out  Width  combinational ISPR read data
acc_wr_en_i  in  1  ISPR write enable
acc_wr_idx_i  in  AccW  ISPR write index
acc_wr_data_i  in  Width  ISPR write data
sec_wipe_i  in  1  wipe all accumulators with urnd
urnd_data_i  in  Width  wipe data
conflict_err_o  out  1  one-cycle pulse: ISPR write collided with write-back

Clock and reset are decided: one clock, clk_i; rst_ni, asynchronous, active-low.

Behaviour:
- Reset: FSM=IDLE; all accumulators, sum, step counter and latched operands cleared to 0; busy_o, done_o, conflict_err_o=0; result_o, flags_o, flags_en_o=0.
- FSM states IDLE -> BUSY -> DONE -> IDLE.
- IDLE, start_i=1:
  - latch operands and controls;
  - sum <= zero_acc_i ? 0 : acc[acc_sel_i] (snapshot);
  - step <= 0; go to BUSY.
- BUSY, each cycle:
  - sum <= sum + ((a_limb * b_limb) << (MulW*k)), truncated to Width;
  - SINGLE: a_limb=A[a_sel], k=shift;
  - ROW: a_limb=A[step], k=step;
  - product is 2*MulW wide; bits shifted above Width are dropped (shift=NumLimbs-1 keeps only the lower MulW bits of the product);
  - last step (SINGLE: step 0; ROW: step NumLimbs-1) -> DONE.
- DONE, one cycle:
  - done_o=1, result_o=sum;
  - acc[acc_sel] <= shift_acc ? {Width/2 zeros, sum[Width-1:Width/2]} : sum;
  - -> IDLE.
- start_i is not accepted in DONE; the next start is accepted the cycle after DONE.
- busy_o=1 in BUSY and DONE.
- Latency from start to done_o: SINGLE start cycle t -> done_o at t+2; ROW -> t+NumLimbs+1.
- Flags, valid only while done_o=1:
  - L=sum[0]; en_L = shift_acc ? ~wr_hw_upper : 1;
  - M = shift_acc ? sum[Width/2-1] : sum[Width-1]; en_M = shift_acc ? wr_hw_upper : 1;
  - Z = shift_acc ? (sum low half==0) : (sum==0); en_Z = (shift_acc & wr_hw_upper) ? ~(low half==0) : 1;
  - C=0, en_C=0.
- abort_i in BUSY or DONE: -> IDLE next cycle; no accumulator write; done_o forced 0 in that cycle.
- sec_wipe_i: every acc <= urnd_data_i; any in-flight op is aborted (no done_o). Priority over ISPR writes.
- ISPR write: acc[acc_wr_idx] <= acc_wr_data, in any state.
  - In-flight ops use their start-time snapshot.
  - ISPR write in the DONE cycle to the same index: ISPR write wins, write-back dropped, done_o still pulses, conflict_err_o=1 for that cycle.
- acc_rd_data_o = acc[acc_rd_idx_i], combinational. An out-of-range index (NumAcc not a power of 2) returns 0.
- Priority for accumulator writes: sec_wipe > ISPR write > write-back.
- Reset mid-operation: immediate return to the reset state.

Test Plan:
1. SINGLE, zero_acc, A[1]=3, B[2]=5, shift=1 -> done_o at t+2, result=15<<64, acc0=15<<64, Z=0, en_L=en_M=en_Z=1.
2. ROW, acc1=1, A limbs {1,2,3,4}, B[0]=2 -> done_o at t+5, result=1+{8,6,4,2} limb pattern, acc1 updated, acc0 unchanged.
3. SINGLE, shift=3, A[0]=B[0]=2^64-1 -> result upper limb=0x1 (low 64 product bits), high product bits discarded.
4. shift_acc=1, wr_hw_upper=1, sum with low half=0 -> acc={0,upper half}, en_Z=0, en_L=0, en_M=1.
5. ROW, abort_i at step 2 -> no done_o, accumulator unchanged, busy_o low next cycle; then start accepted.
6. ISPR write to acc0 with 0xABC in the DONE cycle of an acc0 op -> acc0=0xABC, conflict_err_o=1; sec_wipe mid-BUSY -> all acc=urnd, no done_o.

Source files
------------

// File: rtl/otbn_mac_bignum_iter_if.sv
// rtl/otbn_mac_bignum_iter_if.sv - Operation, result and accumulator-ISPR bundle for the iterative bignum MAC
interface otbn_mac_bignum_iter_if #(
  parameter int Width  = 256,
  parameter int MulW   = 64,
  parameter int NumAcc = 2
) ();
  localparam int NumLimbs = Width / MulW;
  localparam int SelW     = ($clog2(NumLimbs) > 1) ? $clog2(NumLimbs) : 1;
  localparam int AccW     = ($clog2(NumAcc) > 1) ? $clog2(NumAcc) : 1;

  logic             start_i;
  logic             mode_row_i;
  logic [Width-1:0] operand_a_i;
  logic [Width-1:0] operand_b_i;
  logic [SelW-1:0]  a_sel_i;
  logic [SelW-1:0]  b_sel_i;
  logic [SelW-1:0]  shift_i;
  logic             zero_acc_i;
  logic             shift_acc_i;
  logic             wr_hw_upper_i;
  logic [AccW-1:0]  acc_sel_i;
  logic             abort_i;
  logic             busy_o;
  logic             done_o;
  logic [Width-1:0] result_o;
  logic [3:0]       flags_o;
  logic [3:0]       flags_en_o;
  logic [AccW-1:0]  acc_rd_idx_i;
  logic [Width-1:0] acc_rd_data_o;
  logic             acc_wr_en_i;
  logic [AccW-1:0]  acc_wr_idx_i;
  logic [Width-1:0] acc_wr_data_i;
  logic             sec_wipe_i;
  logic [Width-1:0] urnd_data_i;
  logic             conflict_err_o;

  modport master (
    output start_i, mode_row_i, operand_a_i, operand_b_i, a_sel_i, b_sel_i, shift_i,
           zero_acc_i, shift_acc_i, wr_hw_upper_i, acc_sel_i, abort_i,
           acc_rd_idx_i, acc_wr_en_i, acc_wr_idx_i, acc_wr_data_i, sec_wipe_i, urnd_data_i,
    input  busy_o, done_o, result_o, flags_o, flags_en_o, acc_rd_data_o, conflict_err_o
  );

  modport slave (
    input  start_i, mode_row_i, operand_a_i, operand_b_i, a_sel_i, b_sel_i, shift_i,
           zero_acc_i, shift_acc_i, wr_hw_upper_i, acc_sel_i, abort_i,
           acc_rd_idx_i, acc_wr_en_i, acc_wr_idx_i, acc_wr_data_i, sec_wipe_i, urnd_data_i,
    output busy_o, done_o, result_o, flags_o, flags_en_o, acc_rd_data_o, conflict_err_o
  );
endinterface

// File: rtl/otbn_mac_bignum_iter.sv
// rtl/otbn_mac_bignum_iter.sv - Multi-cycle bignum MAC: one MulW x MulW multiplier, NumAcc accumulators, SINGLE/ROW modes
module otbn_mac_bignum_iter #(
  parameter int Width  = 256,
  parameter int MulW   = 64,
  parameter int NumAcc = 2
) (
  input logic                   clk_i,
  input logic                   rst_ni,
  otbn_mac_bignum_iter_if.slave bus
);
  localparam int NumLimbs = Width / MulW;
  localparam int SelW     = ($clog2(NumLimbs) > 1) ? $clog2(NumLimbs) : 1;
  localparam int AccW     = ($clog2(NumAcc) > 1) ? $clog2(NumAcc) : 1;
  localparam int HalfW    = Width / 2;
  localparam logic [SelW-1:0] LastStep = SelW'(NumLimbs - 1);

  if (Width % MulW != 0) begin : g_width_check
    $error("otbn_mac_bignum_iter: Width must be a multiple of MulW");
  end

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e           state_q;
  logic [Width-1:0] sum_q;
  logic [SelW-1:0]  step_q;
  logic             mode_row_q;
  logic [Width-1:0] a_q, b_q;
  logic [SelW-1:0]  a_sel_q, b_sel_q, shift_q;
  logic             shift_acc_q, wr_hw_upper_q;
  logic [AccW-1:0]  acc_sel_q;
  logic [Width-1:0] result_q;
  logic [3:0]       flags_q, flags_en_q;
  logic [Width-1:0] acc_q [NumAcc];

  // Operand limbs come from the start-time latch, so the controller may move on.
  logic [MulW-1:0] a_limbs [NumLimbs];
  logic [MulW-1:0] b_limbs [NumLimbs];
  for (genvar i = 0; i < NumLimbs; i++) begin : g_limbs
    assign a_limbs[i] = a_q[i*MulW +: MulW];
    assign b_limbs[i] = b_q[i*MulW +: MulW];
  end

  logic [SelW-1:0]   a_idx, k_idx;
  logic [MulW-1:0]   a_limb, b_limb;
  logic [2*MulW-1:0] product;
  logic [Width-1:0]  addend, sum_next;
  logic              last_step;

  assign a_idx   = mode_row_q ? step_q : a_sel_q;
  assign k_idx   = mode_row_q ? step_q : shift_q;
  assign a_limb  = (int'(a_idx) < NumLimbs) ? a_limbs[a_idx] : '0;
  assign b_limb  = (int'(b_sel_q) < NumLimbs) ? b_limbs[b_sel_q] : '0;
  assign product = {{MulW{1'b0}}, a_limb} * {{MulW{1'b0}}, b_limb};
  // Product bits pushed above Width by the limb shift are discarded.
  assign addend    = Width'((Width+MulW)'(product) << (MulW * int'(k_idx)));
  assign sum_next  = sum_q + addend;
  assign last_step = ~mode_row_q | (step_q == LastStep);

  logic       low_zero;
  logic [3:0] flags_d, flags_en_d;
  assign low_zero   = ~|sum_next[HalfW-1:0];
  assign flags_d    = {shift_acc_q ? low_zero : ~|sum_next,
                       sum_next[0],
                       shift_acc_q ? sum_next[HalfW-1] : sum_next[Width-1],
                       1'b0};
  assign flags_en_d = {(shift_acc_q & wr_hw_upper_q) ? ~low_zero : 1'b1,
                       shift_acc_q ? ~wr_hw_upper_q : 1'b1,
                       shift_acc_q ? wr_hw_upper_q : 1'b1,
                       1'b0};

  logic [Width-1:0] acc_snap;
  assign acc_snap = (int'(bus.acc_sel_i) < NumAcc) ? acc_q[bus.acc_sel_i] : '0;

  logic cancel;
  assign cancel = bus.abort_i | bus.sec_wipe_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= StIdle;
      sum_q         <= '0;
      step_q        <= '0;
      mode_row_q    <= 1'b0;
      a_q           <= '0;
      b_q           <= '0;
      a_sel_q       <= '0;
      b_sel_q       <= '0;
      shift_q       <= '0;
      shift_acc_q   <= 1'b0;
      wr_hw_upper_q <= 1'b0;
      acc_sel_q     <= '0;
      result_q      <= '0;
      flags_q       <= '0;
      flags_en_q    <= '0;
    end else begin
      result_q   <= '0;
      flags_q    <= '0;
      flags_en_q <= '0;
      unique case (state_q)
        StIdle: begin
          if (bus.start_i) begin
            mode_row_q    <= bus.mode_row_i;
            a_q           <= bus.operand_a_i;
            b_q           <= bus.operand_b_i;
            a_sel_q       <= bus.a_sel_i;
            b_sel_q       <= bus.b_sel_i;
            shift_q       <= bus.shift_i;
            shift_acc_q   <= bus.shift_acc_i;
            wr_hw_upper_q <= bus.wr_hw_upper_i;
            acc_sel_q     <= bus.acc_sel_i;
            sum_q         <= bus.zero_acc_i ? '0 : acc_snap;
            step_q        <= '0;
            state_q       <= StBusy;
          end
        end
        StBusy: begin
          if (cancel) begin
            state_q <= StIdle;
          end else begin
            sum_q  <= sum_next;
            step_q <= step_q + 1'b1;
            if (last_step) begin
              result_q   <= sum_next;
              flags_q    <= flags_d;
              flags_en_q <= flags_en_d;
              state_q    <= StDone;
            end
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  logic             wb_en;
  logic [Width-1:0] wb_data;
  assign wb_en   = (state_q == StDone) & ~cancel;
  assign wb_data = shift_acc_q ? {{(Width-HalfW){1'b0}}, result_q[Width-1:HalfW]} : result_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumAcc; i++) acc_q[i] <= '0;
    end else begin
      for (int i = 0; i < NumAcc; i++) begin
        if (bus.sec_wipe_i) begin
          acc_q[i] <= bus.urnd_data_i;
        end else if (bus.acc_wr_en_i && (bus.acc_wr_idx_i == AccW'(i))) begin
          acc_q[i] <= bus.acc_wr_data_i;
        end else if (wb_en && (acc_sel_q == AccW'(i))) begin
          acc_q[i] <= wb_data;
        end
      end
    end
  end

  assign bus.busy_o         = (state_q != StIdle);
  assign bus.done_o         = wb_en;
  assign bus.result_o       = result_q;
  assign bus.flags_o        = flags_q;
  assign bus.flags_en_o     = flags_en_q;
  assign bus.conflict_err_o = wb_en & bus.acc_wr_en_i & (bus.acc_wr_idx_i == acc_sel_q);
  assign bus.acc_rd_data_o  = (int'(bus.acc_rd_idx_i) < NumAcc) ? acc_q[bus.acc_rd_idx_i] : '0;
endmodule
